acc_scheduler: RTL and testbench
================================

Name: acc_scheduler

Overview:
Time-multiplexes one external pipelined FP adder (FP_ADD, latency Pipeline_Stages) across Channels independent accumulation streams. Each channel has its own accumulator register and element counter. Channels are issued round-robin, so independent channels fill the adder pipeline while each channel has at most one operation in flight. The block sits between the per-channel input streams and the shared FP_ADD instance, and emits one completed sum per channel every AccumulateCount inputs.

Parameters:
DataWidth, 32, operand/accumulator width (IEEE-754 single).
Channels, 4, number of requesting channels.
ChannelWidth, 2, log2(Channels); width of channel id.
Pipeline_Stages, 7, FP_ADD latency in clocks (operands to result).
AccumulateCount, 2, inputs summed per output result.
CountWidth, 1, width of per-channel element counter; must satisfy 2^CountWidth >= AccumulateCount.

Ports:
clk  in  1  clock, rising edge.
aclr  in  1  asynchronous reset, active-high.
sclr  in  1  synchronous clear, active-high.
req_valid  in  Channels  per-channel input valid.
req_data  in  Channels*DataWidth  channel i at bits [i*DataWidth +: DataWidth].
req_rdy  out  Channels  one-hot grant; input consumed when req_valid[i] & req_rdy[i].
add_dataa  out  DataWidth  to FP_ADD dataa: granted channel's req_data.
add_datab  out  DataWidth  to FP_ADD datab: granted channel's accumulator.
issue_valid  out  1  an operation is issued this cycle.
add_result  in  DataWidth  from FP_ADD result.
DataOutValid  out  1  one-cycle pulse: completed sum available.
DataOutChan  out  ChannelWidth  channel id of the completed sum.
DataOut  out  DataWidth  completed sum.

Behaviour:
- Reset: aclr is async and active-high; clock is clk. aclr zeroes all accumulators, counters, busy flags and tag-pipeline valids, and sets the RR pointer so channel 0 has top priority. Outputs in reset: req_rdy=0, issue_valid=0, DataOutValid=0, DataOutChan=0, DataOut=0. add_dataa/add_datab are don't-care.
- Eligibility: channel i is eligible when req_valid[i] & ~busy[i] & ~sclr.
- Arbitration (combinational, same cycle): grant the first eligible channel, searching from (last_grant+1) mod Channels. req_rdy is one-hot or all-zero. issue_valid = |req_rdy. The pointer updates to the granted channel only on issue.
- Issue in cycle t0:
  - add_dataa = req_data[g], add_datab = acc[g].
  - busy[g] <= 1.
  - A tag {valid=1, chan=g} enters a Pipeline_Stages-deep shift register. The register shifts every cycle; a bubble tag has valid=0.
- Writeback in cycle t0+Pipeline_Stages, when the tag at the shift-register output is valid with chan=c. add_result is valid in this cycle. At the closing edge:
  - busy[c] <= 0.
  - If cnt[c] != AccumulateCount-1: acc[c] <= add_result and cnt[c] <= cnt[c]+1.
  - Else: acc[c] <= 0, cnt[c] <= 0, and DataOut <= add_result, DataOutChan <= c, DataOutValid <= 1 for exactly cycle t0+Pipeline_Stages+1.
- Output registers: DataOutValid is 0 on every other cycle. DataOut and DataOutChan hold their last values when not valid. There is no output backpressure.
- Channel re-issue: a channel is re-eligible no earlier than cycle t0+Pipeline_Stages+1, with no result bypass. Its next issue uses the updated acc.
- Throughput: with at least Pipeline_Stages+1 active channels, one issue per cycle is possible. With fewer, each channel issues once per Pipeline_Stages+1 cycles.
- Only one tag exits per cycle, so writebacks never collide. Issue and writeback of different channels in the same cycle are independent.
- Per-channel sums are order-preserving: inputs of one channel are added in acceptance order.
- sclr (synchronous, priority over all updates):
  - Clears acc, cnt, busy, all tag valids, the RR pointer and DataOutValid.
  - Forces req_rdy=0 in that cycle, so no input is consumed.
  - In-flight results are discarded; add_result is ignored until new tags emerge.
- aclr mid-operation: immediate return to reset state; in-flight work is lost.
- The first addition of each sum uses acc=0 (+0.0), so the first element passes through unchanged.

Test Plan:
- Single channel 0: inputs 0x3F800000 (1.0) then 0x40000000 (2.0), AccumulateCount=2 -> the second input is accepted no earlier than 8 cycles after the first. DataOutValid pulses once, at 8 cycles after the second issue, with DataOutChan=0 and DataOut=0x40400000 (3.0). acc[0] is then 0.
- All 4 channels valid continuously from reset -> req_rdy is 0001, 0010, 0100, 1000 on consecutive cycles. Then no grant until channel 0 writes back, and channel 0 is re-granted on cycle 8 after its first issue.
- Channel 2 busy while channels 1 and 3 are valid and last_grant=1 -> channel 3 is granted. After channel 2 frees, the RR order continues 0, 1, 2.
- Channels 0 and 1 each get 2.0+2.0 -> two DataOutValid pulses on consecutive cycles, DataOut=0x40800000 (4.0), DataOutChan 0 then 1.
- sclr asserted 3 cycles after the issue of channel 0's first element -> req_rdy=0 in the sclr cycle and no DataOutValid ever for that operation. A fresh 1.0+1.0 afterwards yields 0x40000000 (2.0).
- aclr pulsed mid-stream with 4 channels in flight -> all outputs 0 immediately, no stale DataOutValid after release. Accumulation restarts from zero.

Source files
------------

// File: rtl/acc_scheduler_if.sv
// Request, adder and result signals between the accumulation scheduler and its environment.
// The scheduler is the slave: it accepts channel inputs and drives the shared FP adder.
interface acc_scheduler_if #(
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned Channels     = 4,
    parameter int unsigned ChannelWidth = 2
);
    logic [Channels-1:0]           req_valid;
    logic [Channels*DataWidth-1:0] req_data;
    logic [Channels-1:0]           req_rdy;
    logic [DataWidth-1:0]          add_dataa;
    logic [DataWidth-1:0]          add_datab;
    logic                          issue_valid;
    logic [DataWidth-1:0]          add_result;
    logic                          DataOutValid;
    logic [ChannelWidth-1:0]       DataOutChan;
    logic [DataWidth-1:0]          DataOut;

    modport master (
        output req_valid, req_data, add_result,
        input  req_rdy, add_dataa, add_datab, issue_valid, DataOutValid, DataOutChan, DataOut
    );

    modport slave (
        input  req_valid, req_data, add_result,
        output req_rdy, add_dataa, add_datab, issue_valid, DataOutValid, DataOutChan, DataOut
    );
endinterface

// File: rtl/acc_scheduler.sv
// Round-robin scheduler sharing one pipelined FP adder across independent accumulation channels.
// Each channel keeps at most one addition in flight; a tag pipeline tracks whose result emerges.
module acc_scheduler #(
    parameter int unsigned DataWidth       = 32,
    parameter int unsigned Channels        = 4,
    parameter int unsigned ChannelWidth    = 2,
    parameter int unsigned Pipeline_Stages = 7,
    parameter int unsigned AccumulateCount = 2,
    parameter int unsigned CountWidth      = 1
) (
    input logic            clk,
    input logic            aclr,
    input logic            sclr,
    acc_scheduler_if.slave bus
);
    localparam logic [ChannelWidth-1:0] LastRst = ChannelWidth'(Channels - 1);
    localparam logic [CountWidth-1:0]   CntLast = CountWidth'(AccumulateCount - 1);

    logic [DataWidth-1:0]       req_word   [Channels];
    logic [DataWidth-1:0]       acc_q      [Channels];
    logic [DataWidth-1:0]       acc_d      [Channels];
    logic [CountWidth-1:0]      cnt_q      [Channels];
    logic [CountWidth-1:0]      cnt_d      [Channels];
    logic [ChannelWidth-1:0]    tag_chan_q [Pipeline_Stages];
    logic [ChannelWidth-1:0]    tag_chan_d [Pipeline_Stages];
    logic [Channels-1:0]        busy_q, busy_d;
    logic [ChannelWidth-1:0]    last_q, last_d;
    logic [Pipeline_Stages-1:0] tag_vld_q, tag_vld_d;
    logic                       dout_valid_q, dout_valid_d;
    logic [ChannelWidth-1:0]    dout_chan_q, dout_chan_d;
    logic [DataWidth-1:0]       dout_q, dout_d;

    logic [Channels-1:0]     eligible;
    logic                    grant_found;
    logic [ChannelWidth-1:0] grant_idx;
    logic [ChannelWidth-1:0] cand;
    logic                    wb_valid;
    logic [ChannelWidth-1:0] wb_chan;
    logic                    wb_last;

    for (genvar i = 0; i < Channels; i++) begin : g_unpack
        assign req_word[i] = bus.req_data[i*DataWidth +: DataWidth];
    end

    // aclr gating keeps req_rdy low while the block is held in reset.
    assign eligible = bus.req_valid & ~busy_q & {Channels{~(sclr | aclr)}};

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned k = 1; k <= Channels; k++) begin
            cand = ChannelWidth'((32'(last_q) + k) % Channels);
            if (!grant_found && eligible[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign wb_valid = tag_vld_q[Pipeline_Stages-1];
    assign wb_chan  = tag_chan_q[Pipeline_Stages-1];
    assign wb_last  = (cnt_q[wb_chan] == CntLast);

    always_comb begin
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        busy_d       = busy_q;
        last_d       = last_q;
        tag_vld_d    = (tag_vld_q << 1) | Pipeline_Stages'(grant_found);
        tag_chan_d   = tag_chan_q;
        dout_valid_d = 1'b0;
        dout_chan_d  = dout_chan_q;
        dout_d       = dout_q;

        tag_chan_d[0] = grant_idx;
        for (int unsigned i = 1; i < Pipeline_Stages; i++) begin
            tag_chan_d[i] = tag_chan_q[i-1];
        end

        if (grant_found) begin
            busy_d[grant_idx] = 1'b1;
            last_d            = grant_idx;
        end

        // The granted channel is never the one writing back, since the latter is still busy.
        if (wb_valid) begin
            busy_d[wb_chan] = 1'b0;
            if (wb_last) begin
                acc_d[wb_chan] = '0;
                cnt_d[wb_chan] = '0;
                dout_valid_d   = 1'b1;
                dout_chan_d    = wb_chan;
                dout_d         = bus.add_result;
            end else begin
                acc_d[wb_chan] = bus.add_result;
                cnt_d[wb_chan] = cnt_q[wb_chan] + CountWidth'(1);
            end
        end

        if (sclr) begin
            for (int unsigned i = 0; i < Channels; i++) begin
                acc_d[i] = '0;
                cnt_d[i] = '0;
            end
            busy_d       = '0;
            last_d       = LastRst;
            tag_vld_d    = '0;
            dout_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            for (int unsigned i = 0; i < Channels; i++) begin
                acc_q[i] <= '0;
                cnt_q[i] <= '0;
            end
            for (int unsigned i = 0; i < Pipeline_Stages; i++) begin
                tag_chan_q[i] <= '0;
            end
            busy_q       <= '0;
            last_q       <= LastRst;
            tag_vld_q    <= '0;
            dout_valid_q <= 1'b0;
            dout_chan_q  <= '0;
            dout_q       <= '0;
        end else begin
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            tag_chan_q   <= tag_chan_d;
            busy_q       <= busy_d;
            last_q       <= last_d;
            tag_vld_q    <= tag_vld_d;
            dout_valid_q <= dout_valid_d;
            dout_chan_q  <= dout_chan_d;
            dout_q       <= dout_d;
        end
    end

    assign bus.req_rdy      = grant_found ? (Channels'(1) << grant_idx) : '0;
    assign bus.issue_valid  = grant_found;
    assign bus.add_dataa    = req_word[grant_idx];
    assign bus.add_datab    = acc_q[grant_idx];
    assign bus.DataOutValid = dout_valid_q;
    assign bus.DataOutChan  = dout_chan_q;
    assign bus.DataOut      = dout_q;
endmodule

// File: tb/tb_acc_scheduler.sv
// Directed bench for acc_scheduler with a behavioural 7-stage FP adder and an output scoreboard.
module tb_acc_scheduler;
    localparam int PS = 7;
    localparam logic [31:0] ONE   = 32'h3F800000;
    localparam logic [31:0] TWO   = 32'h40000000;
    localparam logic [31:0] THREE = 32'h40400000;
    localparam logic [31:0] FOUR  = 32'h40800000;

    typedef struct packed {
        logic [1:0]  chan;
        logic [31:0] data;
    } exp_t;

    logic clk;
    logic aclr;
    logic sclr;
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];
    logic [31:0] add_pipe [PS];

    acc_scheduler_if #(.DataWidth(32), .Channels(4), .ChannelWidth(2)) bus ();

    acc_scheduler #(
        .DataWidth(32), .Channels(4), .ChannelWidth(2),
        .Pipeline_Stages(PS), .AccumulateCount(2), .CountWidth(1)
    ) u_dut (
        .clk (clk),
        .aclr(aclr),
        .sclr(sclr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-precision <-> real conversion, valid for zero and normal numbers.
    function automatic real f2r(input logic [31:0] b);
        logic [10:0] e;
        if (b[30:0] == 31'd0) return 0.0;
        e = {3'd0, b[30:23]} + 11'd896;
        return $bitstoreal({b[31], e, b[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return 32'd0;
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    always @(posedge clk) begin
        add_pipe[0] <= r2f(f2r(bus.add_dataa) + f2r(bus.add_datab));
        for (int i = PS - 1; i > 0; i--) add_pipe[i] <= add_pipe[i-1];
    end
    assign bus.add_result = add_pipe[PS-1];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] c, input logic [31:0] d);
        exp_t e;
        e.chan = c;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic set_all(input logic [31:0] v);
        for (int ch = 0; ch < 4; ch++) bus.req_data[ch*32 +: 32] = v;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic do_sclr();
        next();
        bus.req_valid = 4'b0011;
        sclr = 1'b1;
        #2 check("sclr_rdy", 64'(bus.req_rdy), 64'h0);
        next();
        sclr = 1'b0;
        bus.req_valid = 4'b0000;
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (bus.DataOutValid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", {30'd0, bus.DataOutChan, bus.DataOut}, 64'h0);
            end else begin
                e = exp_q.pop_front();
                check("out_chan", 64'(bus.DataOutChan), 64'(e.chan));
                check("out_data", 64'(bus.DataOut), 64'(e.data));
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        aclr = 1'b1;
        sclr = 1'b0;
        bus.req_valid = 4'hF;
        set_all(32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_rdy", 64'(bus.req_rdy), 64'h0);
        check("rst_issue", 64'(bus.issue_valid), 64'h0);
        check("rst_dov", 64'(bus.DataOutValid), 64'h0);
        check("rst_chan", 64'(bus.DataOutChan), 64'h0);
        check("rst_data", 64'(bus.DataOut), 64'h0);
        aclr = 1'b0;
        bus.req_valid = 4'h0;

        // Single channel 0: 1.0 + 2.0
        next();
        bus.req_valid = 4'b0001;
        bus.req_data[31:0] = ONE;
        #2 check("t1_grant0", 64'(bus.req_rdy), 64'h1);
        check("t1_issue", 64'(bus.issue_valid), 64'h1);
        for (int k = 1; k < 8; k++) begin
            next();
            if (k == 1) bus.req_data[31:0] = TWO;
            #2 check("t1_busy", 64'(bus.req_rdy), 64'h0);
        end
        next();
        #2 check("t1_grant1", 64'(bus.req_rdy), 64'h1);
        push(2'd0, THREE);
        for (int k = 1; k <= 8; k++) begin
            next();
            if (k == 1) bus.req_valid = 4'b0000;
            #2 check("t1_dov_time", 64'(bus.DataOutValid), 64'(k == 8));
        end

        // Channels 0 and 1: 2.0 + 2.0 each; ch0 starts from a freshly cleared accumulator
        next();
        bus.req_valid = 4'b0001;
        set_all(TWO);
        #2 check("t4_g0", 64'(bus.req_rdy), 64'h1);
        next();
        bus.req_valid = 4'b0011;
        #2 check("t4_g1", 64'(bus.req_rdy), 64'h2);
        for (int k = 2; k < 8; k++) begin
            next();
            #2 check("t4_busy", 64'(bus.req_rdy), 64'h0);
        end
        next();
        #2 check("t4_re0", 64'(bus.req_rdy), 64'h1);
        push(2'd0, FOUR);
        next();
        #2 check("t4_re1", 64'(bus.req_rdy), 64'h2);
        push(2'd1, FOUR);
        for (int k = 1; k <= 9; k++) begin
            next();
            if (k == 1) bus.req_valid = 4'b0000;
            #2 check("t4_dov_time", 64'(bus.DataOutValid), 64'(k == 7 || k == 8));
        end

        // All four channels valid from a cleared pointer
        do_sclr();
        bus.req_valid = 4'hF;
        set_all(ONE);
        #2 check("t2_g0", 64'(bus.req_rdy), 64'h1);
        for (int k = 1; k < 4; k++) begin
            next();
            #2 check("t2_rr", 64'(bus.req_rdy), 64'h1 << k);
        end
        for (int k = 4; k < 8; k++) begin
            next();
            #2 check("t2_stall", 64'(bus.req_rdy), 64'h0);
        end
        for (int k = 8; k < 12; k++) begin
            next();
            #2 check("t2_rr2", 64'(bus.req_rdy), 64'h1 << (k - 8));
            push(2'(k - 8), TWO);
        end
        for (int k = 1; k <= 9; k++) begin
            next();
            if (k == 1) bus.req_valid = 4'h0;
            #2 check("t2_dov_time", 64'(bus.DataOutValid), 64'(k >= 5 && k <= 8));
        end

        // Busy channel 2 is skipped when last_grant = 1
        do_sclr();
        bus.req_valid = 4'b0100;
        #2 check("t3_g2", 64'(bus.req_rdy), 64'h4);
        next();
        bus.req_valid = 4'b0010;
        #2 check("t3_g1", 64'(bus.req_rdy), 64'h2);
        next();
        bus.req_valid = 4'b1110;
        #2 check("t3_skip2", 64'(bus.req_rdy), 64'h8);
        next();
        bus.req_valid = 4'b0000;
        repeat (5) next();
        next();
        bus.req_valid = 4'b0111;
        #2 check("t3_rr0", 64'(bus.req_rdy), 64'h1);
        next();
        #2 check("t3_rr1", 64'(bus.req_rdy), 64'h2);
        push(2'd1, TWO);
        next();
        #2 check("t3_rr2", 64'(bus.req_rdy), 64'h4);
        push(2'd2, TWO);
        for (int k = 1; k <= 9; k++) begin
            next();
            if (k == 1) bus.req_valid = 4'b0000;
            #2 check("t3_dov_time", 64'(bus.DataOutValid), 64'(k == 7 || k == 8));
        end

        // sclr three cycles after an issue discards the in-flight result
        do_sclr();
        bus.req_valid = 4'b0001;
        set_all(ONE);
        #2 check("t5_g0", 64'(bus.req_rdy), 64'h1);
        next();
        next();
        next();
        sclr = 1'b1;
        bus.req_valid = 4'b0011;
        #2 check("t5_sclr_rdy", 64'(bus.req_rdy), 64'h0);
        next();
        sclr = 1'b0;
        bus.req_valid = 4'b0001;
        #2 check("t5_fresh", 64'(bus.req_rdy), 64'h1);
        for (int k = 5; k < 12; k++) begin
            next();
            #2 check("t5_busy", 64'(bus.req_rdy), 64'h0);
            check("t5_no_dov", 64'(bus.DataOutValid), 64'h0);
        end
        next();
        #2 check("t5_g1", 64'(bus.req_rdy), 64'h1);
        push(2'd0, TWO);
        for (int k = 1; k <= 8; k++) begin
            next();
            if (k == 1) bus.req_valid = 4'b0000;
            #2 check("t5_dov_time", 64'(bus.DataOutValid), 64'(k == 8));
        end

        // aclr with second-round operations in flight on all channels
        next();
        bus.req_valid = 4'hF;
        set_all(ONE);
        repeat (11) next();
        next();
        aclr = 1'b1;
        #2 check("t6_rdy", 64'(bus.req_rdy), 64'h0);
        check("t6_issue", 64'(bus.issue_valid), 64'h0);
        check("t6_dov", 64'(bus.DataOutValid), 64'h0);
        check("t6_chan", 64'(bus.DataOutChan), 64'h0);
        check("t6_data", 64'(bus.DataOut), 64'h0);
        next();
        next();
        aclr = 1'b0;
        bus.req_valid = 4'h0;
        for (int k = 0; k < 12; k++) begin
            next();
            #2 check("t6_no_stale", 64'(bus.DataOutValid), 64'h0);
        end
        next();
        bus.req_valid = 4'b0001;
        bus.req_data[31:0] = ONE;
        #2 check("t6_restart", 64'(bus.req_rdy), 64'h1);
        for (int k = 1; k < 8; k++) begin
            next();
            if (k == 1) bus.req_data[31:0] = TWO;
            #2 check("t6_busy", 64'(bus.req_rdy), 64'h0);
        end
        next();
        #2 check("t6_g1", 64'(bus.req_rdy), 64'h1);
        push(2'd0, THREE);
        for (int k = 1; k <= 8; k++) begin
            next();
            if (k == 1) bus.req_valid = 4'b0000;
            #2 check("t6_dov_time", 64'(bus.DataOutValid), 64'(k == 8));
        end

        next();
        check("pending_results", 64'(exp_q.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
